// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between a fetch and a data requester.
// Data has priority, bounded by a starvation counter; stalled transactions abort on timeout.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        FetchReq,
   input  logic [31:0] FetchAddr,
   output logic        FetchAck,
   output logic [31:0] FetchRData,
   input  logic        DataReq,
   input  logic        DataWEn,
   input  logic [31:0] DataAddr,
   input  logic [31:0] DataWData,
   output logic        DataAck,
   output logic [31:0] DataRData,
   output logic        Err,
   output logic        MemReq,
   output logic        MemWEn,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   input  logic        MemAck,
   input  logic [31:0] MemRData
);
   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;
   state_t      state_q;
   logic        mem_req_q, mem_wen_q, fetch_ack_q, data_ack_q, err_q;
   logic [31:0] mem_addr_q, mem_wdata_q, fetch_rdata_q, data_rdata_q;
   logic [3:0]  starve_q, starve_d;
   logic [7:0]  tmo_q;
   logic        arb_en, grant_f, grant_d, done;
   always_comb begin
      // Nobody is granted in an Ack cycle: the acked requester's Req is stale, and
      // letting the other side in there would make data back-to-back grants impossible.
      arb_en   = state_q == IDLE && !fetch_ack_q && !data_ack_q;
      grant_f  = arb_en && FetchReq && (!DataReq || starve_q == 4'(STARVE_LIMIT));
      grant_d  = arb_en && DataReq && !grant_f;
      starve_d = grant_f ? '0 : grant_d ? (FetchReq ? starve_q + 4'd1 : '0) : starve_q;
      done     = state_q != IDLE && (MemAck || tmo_q == 8'(TIMEOUT - 1));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_wen_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         fetch_ack_q   <= 1'b0;
         data_ack_q    <= 1'b0;
         err_q         <= 1'b0;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
         starve_q      <= '0;
         tmo_q         <= '0;
      end else begin
         fetch_ack_q <= 1'b0;
         data_ack_q  <= 1'b0;
         err_q       <= 1'b0;
         starve_q    <= starve_d;
         if (grant_f || grant_d) begin
            state_q     <= grant_f ? BUSY_F : BUSY_D;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= grant_f ? FetchAddr : DataAddr;
            mem_wdata_q <= grant_f ? '0 : DataWData;
            mem_wen_q   <= grant_d && DataWEn;
            tmo_q       <= '0;
         end else if (done) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            err_q       <= !MemAck;
            fetch_ack_q <= state_q == BUSY_F;
            data_ack_q  <= state_q == BUSY_D;
            if (state_q == BUSY_F)
               fetch_rdata_q <= MemAck ? MemRData : '0;
            else if (!MemAck || !mem_wen_q)
               data_rdata_q <= MemAck ? MemRData : '0;
         end else if (state_q != IDLE) begin
            tmo_q <= tmo_q + 8'd1;
         end
      end
   end
   assign FetchAck   = fetch_ack_q;
   assign FetchRData = fetch_rdata_q;
   assign DataAck    = data_ack_q;
   assign DataRData  = data_rdata_q;
   assign Err        = err_q;
   assign MemReq     = mem_req_q;
   assign MemWEn     = mem_wen_q;
   assign MemAddr    = mem_addr_q;
   assign MemWData   = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with default parameters.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        FetchReq = 1'b0, DataReq = 1'b0, DataWEn = 1'b0, MemAck = 1'b0;
   logic [31:0] FetchAddr = '0, DataAddr = '0, DataWData = '0, MemRData = '0;
   logic        FetchAck, DataAck, Err, MemReq, MemWEn;
   logic [31:0] FetchRData, DataRData, MemAddr, MemWData;
   int          checks = 0, errors = 0;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck), .FetchRData(FetchRData),
      .DataReq(DataReq), .DataWEn(DataWEn), .DataAddr(DataAddr), .DataWData(DataWData),
      .DataAck(DataAck), .DataRData(DataRData), .Err(Err),
      .MemReq(MemReq), .MemWEn(MemWEn), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemAck(MemAck), .MemRData(MemRData)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_memreq"}, 32'(MemReq), 0);
      chk({tag, "_memwen"}, 32'(MemWEn), 0);
      chk({tag, "_memaddr"}, MemAddr, 0);
      chk({tag, "_memwdata"}, MemWData, 0);
      chk({tag, "_acks_err"}, {29'd0, FetchAck, DataAck, Err}, 0);
      chk({tag, "_frdata"}, FetchRData, 0);
      chk({tag, "_drdata"}, DataRData, 0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_async");
      tick();
      tick();
      chk_all_zero("rst_hold");
      @(negedge clk) rst_n = 1'b1;
      tick();

      // fetch only, minimum latency, then stale Req and late MemAck
      FetchReq = 1'b1; FetchAddr = 32'h100;
      tick();
      chk("f_memreq", 32'(MemReq), 1);
      chk("f_memaddr", MemAddr, 32'h100);
      chk("f_memwen", 32'(MemWEn), 0);
      MemAck = 1'b1; MemRData = 32'h13;
      tick();
      chk("f_ack", {30'd0, FetchAck, DataAck}, 32'b10);
      chk("f_rdata", FetchRData, 32'h13);
      chk("f_memreq_low", 32'(MemReq), 0);
      chk("f_err", 32'(Err), 0);
      tick();
      chk("stale_no_regrant", 32'(MemReq), 0);
      chk("late_ack_ignored", {30'd0, FetchAck, DataAck}, 0);
      FetchReq = 1'b0; MemAck = 1'b0;
      tick();

      // simultaneous: data store first, then fetch
      FetchReq = 1'b1; FetchAddr = 32'h104;
      DataReq = 1'b1; DataWEn = 1'b1; DataAddr = 32'h200; DataWData = 32'hDEADBEEF;
      tick();
      chk("sim_d_addr", MemAddr, 32'h200);
      chk("sim_d_wen", 32'(MemWEn), 1);
      chk("sim_d_wdata", MemWData, 32'hDEADBEEF);
      MemAck = 1'b1; MemRData = 32'h5555;
      tick();
      chk("sim_d_ack", {30'd0, FetchAck, DataAck}, 32'b01);
      chk("sim_store_no_rdata", DataRData, 0);
      DataReq = 1'b0; MemAck = 1'b0;
      tick();
      chk("sim_gap", 32'(MemReq), 0);
      tick();
      chk("sim_f_grant", {31'd0, MemReq}, 1);
      chk("sim_f_addr", MemAddr, 32'h104);
      chk("sim_f_wen", 32'(MemWEn), 0);
      MemAck = 1'b1; MemRData = 32'hAAAA;
      tick();
      chk("sim_f_ack", {30'd0, FetchAck, DataAck}, 32'b10);
      chk("sim_f_rdata", FetchRData, 32'hAAAA);
      FetchReq = 1'b0; MemAck = 1'b0;
      tick();

      // starvation: 4 data loads back-to-back, then fetch
      FetchReq = 1'b1; FetchAddr = 32'h300;
      DataReq = 1'b1; DataWEn = 1'b0; DataAddr = 32'h400;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("starve_d%0d_addr", i), MemAddr, 32'h400);
         MemAck = 1'b1; MemRData = 32'h50 + 32'(i);
         tick();
         chk($sformatf("starve_d%0d_ack", i), {30'd0, FetchAck, DataAck}, 32'b01);
         chk($sformatf("starve_d%0d_rdata", i), DataRData, 32'h50 + 32'(i));
         MemAck = 1'b0;
         tick();
      end
      tick();
      chk("starve_f_addr", MemAddr, 32'h300);
      chk("starve_f_wen", 32'(MemWEn), 0);
      chk("starve_cnt_clear", 32'(dut.starve_q), 0);
      MemAck = 1'b1; MemRData = 32'h77;
      tick();
      chk("starve_f_ack", {30'd0, FetchAck, DataAck}, 32'b10);
      FetchReq = 1'b0; DataReq = 1'b0; MemAck = 1'b0;
      tick();

      // timeout after 15 BUSY cycles
      DataReq = 1'b1; DataWEn = 1'b0; DataAddr = 32'h500;
      tick();
      for (int k = 2; k <= 15; k++) begin
         tick();
         chk($sformatf("tmo_busy%0d", k), {30'd0, MemReq, DataAck}, 32'b10);
      end
      tick();
      chk("tmo_ack_err", {29'd0, FetchAck, DataAck, Err}, 32'b011);
      chk("tmo_rdata_zero", DataRData, 0);
      chk("tmo_memreq_low", 32'(MemReq), 0);
      DataReq = 1'b0;
      tick();
      chk("tmo_err_pulse", {30'd0, DataAck, Err}, 0);
      tick();

      // MemAck arriving in the 15th BUSY cycle is a success
      DataReq = 1'b1; DataAddr = 32'h504;
      tick();
      for (int k = 2; k <= 15; k++) tick();
      chk("late_ok_busy15", {31'd0, MemReq}, 1);
      MemAck = 1'b1; MemRData = 32'h99;
      tick();
      chk("late_ok_ack_noerr", {30'd0, DataAck, Err}, 32'b10);
      chk("late_ok_rdata", DataRData, 32'h99);
      DataReq = 1'b0; MemAck = 1'b0;
      tick();

      // reset in the middle of BUSY_D aborts it; pending fetch wins after release
      DataReq = 1'b1; DataWEn = 1'b1; DataAddr = 32'h600; DataWData = 32'h1234;
      FetchReq = 1'b1; FetchAddr = 32'h700;
      tick();
      chk("rstbusy_d_grant", MemAddr, 32'h600);
      tick();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rstbusy_async");
      DataReq = 1'b0;
      tick();
      chk("rstbusy_no_ack", {30'd0, FetchAck, DataAck}, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("rstbusy_f_grant", {31'd0, MemReq}, 1);
      chk("rstbusy_f_addr", MemAddr, 32'h700);
      chk("rstbusy_no_dack", 32'(DataAck), 0);
      MemAck = 1'b1; MemRData = 32'hC0DE;
      tick();
      chk("rstbusy_f_ack", {30'd0, FetchAck, DataAck}, 32'b10);
      chk("rstbusy_f_rdata", FetchRData, 32'hC0DE);
      FetchReq = 1'b0; MemAck = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
